// File: rtl/sid_dac_pkg.sv
// Shared SID 8-bit DAC ladder model: per-bit weights, bias and accumulator width.
// Imported by both the DAC and the SAR inverse so the ladder has a single source.
package sid_dac_pkg;

  localparam int SID_DAC_ACC_W = 12;

  localparam logic [SID_DAC_ACC_W-1:0] SID_DAC_BIAS = 12'd8;

  // Non-monotonic ladder: bit k weight, index 0 is the LSB.
  localparam logic [SID_DAC_ACC_W-1:0] SID_DAC_COEF [0:7] = '{
    12'h01d, 12'h02a, 12'h04b, 12'h08d,
    12'h110, 12'h20e, 12'h3fb, 12'h7b8
  };

  typedef enum logic {
    SAR_IDLE = 1'b0,
    SAR_CONV = 1'b1
  } sar_state_e;

endpackage

// File: rtl/sid_dac_coef_rom.sv
// Combinational ladder-weight lookup: 3-bit bit index to 12-bit weight.
module sid_dac_coef_rom
  import sid_dac_pkg::*;
(
  input  logic [2:0]               idx_i,
  output logic [SID_DAC_ACC_W-1:0] weight_o
);

  assign weight_o = SID_DAC_COEF[idx_i];

endmodule

// File: rtl/sid_adc8_sar.sv
// SAR inverse of the SID nonlinear DAC: greedy search for the code whose level is <= target.
// Optional macro SID_ADC_ERR_EN adds oErr = target - oLevel, registered with oCode.
//
// state    | meaning
// SAR_IDLE | waiting for iStart; outputs hold the last result
// SAR_CONV | resolving bit idx_q, MSB first, one bit per cycle
module sid_adc8_sar
  import sid_dac_pkg::*;
#(
  parameter logic [SID_DAC_ACC_W-1:0] BIAS  = SID_DAC_BIAS,
  parameter int                       NBITS = 8
) (
  input  logic       clk,
  input  logic       iRstN,
  input  logic [7:0] iTarget,
  input  logic       iStart,
  output logic       oBusy,
  output logic       oValid,
  output logic [7:0] oCode,
  output logic [7:0] oLevel
`ifdef SID_ADC_ERR_EN
  ,
  output logic [7:0] oErr
`endif
);

  if (NBITS != 8) begin : g_nbits_check
    $error("sid_adc8_sar supports NBITS == 8 only");
  end

  sar_state_e               state_q;
  logic [7:0]               target_q;
  logic [7:0]               code_q;
  logic [SID_DAC_ACC_W-1:0] sum_q;
  logic [2:0]               idx_q;
  logic                     busy_q;
  logic                     valid_q;
  logic [7:0]               out_code_q;
  logic [7:0]               out_level_q;
`ifdef SID_ADC_ERR_EN
  logic [7:0]               err_q;
`endif

  logic [SID_DAC_ACC_W-1:0] weight;
  logic [SID_DAC_ACC_W-1:0] trial;
  logic                     keep;
  logic [7:0]               code_d;
  logic [SID_DAC_ACC_W-1:0] sum_d;

  sid_dac_coef_rom u_coef_rom (
    .idx_i    (idx_q),
    .weight_o (weight)
  );

  // Greedy step: keep bit idx_q only if the rounded level stays at or below target.
  always_comb begin
    trial  = sum_q + weight;
    keep   = (trial[11:4] <= target_q);
    code_d = code_q;
    sum_d  = sum_q;
    if (keep) begin
      code_d = code_q | (8'd1 << idx_q);
      sum_d  = trial;
    end
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      state_q     <= SAR_IDLE;
      target_q    <= '0;
      code_q      <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      out_code_q  <= '0;
      out_level_q <= '0;
`ifdef SID_ADC_ERR_EN
      err_q       <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        SAR_IDLE: begin
          if (iStart) begin
            target_q <= iTarget;
            sum_q    <= BIAS;
            code_q   <= '0;
            idx_q    <= 3'd7;
            busy_q   <= 1'b1;
            state_q  <= SAR_CONV;
          end
        end
        SAR_CONV: begin
          code_q <= code_d;
          sum_q  <= sum_d;
          if (idx_q == 3'd0) begin
            out_code_q  <= code_d;
            out_level_q <= sum_d[11:4];
`ifdef SID_ADC_ERR_EN
            err_q       <= target_q - sum_d[11:4];
`endif
            valid_q     <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= SAR_IDLE;
          end else begin
            idx_q <= idx_q - 3'd1;
          end
        end
        default: begin
          state_q <= SAR_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oBusy  = busy_q;
  assign oValid = valid_q;
  assign oCode  = out_code_q;
  assign oLevel = out_level_q;
`ifdef SID_ADC_ERR_EN
  assign oErr   = err_q;
`endif

endmodule

// File: tb/tb_sid_adc8_sar.sv
// Self-checking bench for sid_adc8_sar: cycle model of busy/valid plus a result scoreboard.
// Build with SID_ADC_ERR_EN defined to also check oErr.
module tb_sid_adc8_sar;

  logic       clk = 1'b0;
  logic       iRstN = 1'b0;
  logic [7:0] iTarget = 8'h00;
  logic       iStart = 1'b0;
  logic       oBusy;
  logic       oValid;
  logic [7:0] oCode;
  logic [7:0] oLevel;
`ifdef SID_ADC_ERR_EN
  logic [7:0] oErr;
`endif

  int n_vec = 0;
  int n_bad = 0;

  sid_adc8_sar dut (
    .clk     (clk),
    .iRstN   (iRstN),
    .iTarget (iTarget),
    .iStart  (iStart),
    .oBusy   (oBusy),
    .oValid  (oValid),
    .oCode   (oCode),
    .oLevel  (oLevel)
`ifdef SID_ADC_ERR_EN
    ,
    .oErr    (oErr)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [11:0] W [0:7] = '{
    12'h01d, 12'h02a, 12'h04b, 12'h08d,
    12'h110, 12'h20e, 12'h3fb, 12'h7b8
  };

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] level;
    logic [7:0] err;
  } res_t;

  function automatic res_t ref_sar(input logic [7:0] t);
    res_t        r;
    logic [11:0] s;
    logic [11:0] tr;
    s      = 12'd8;
    r.code = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      tr = s + W[k];
      if (tr[11:4] <= t) begin
        r.code[k] = 1'b1;
        s = tr;
      end
    end
    r.level = s[11:4];
    r.err   = t - s[11:4];
    return r;
  endfunction

  res_t sb[$];
  logic m_busy = 1'b0;
  logic m_valid = 1'b0;
  int   m_cnt = 0;
  logic [7:0] h_code = 8'h00;
  logic [7:0] h_level = 8'h00;
  logic [7:0] h_err = 8'h00;

  // Cycle model: decides acceptance from the inputs only, pushes the expected result.
  always @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_cnt   = 0;
      h_code  = 8'h00;
      h_level = 8'h00;
      h_err   = 8'h00;
      sb.delete();
    end else if (m_busy) begin
      m_cnt--;
      m_valid = (m_cnt == 0);
      if (m_cnt == 0) m_busy = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (iStart) begin
        sb.push_back(ref_sar(iTarget));
        m_busy = 1'b1;
        m_cnt  = 8;
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    n_vec++;
    if (oBusy !== m_busy) begin
      n_bad++;
      $display("FAIL busy @%0t: got %b want %b", $time, oBusy, m_busy);
    end
    n_vec++;
    if (oValid !== m_valid) begin
      n_bad++;
      $display("FAIL valid @%0t: got %b want %b", $time, oValid, m_valid);
    end
    if (oValid === 1'b1) begin
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_empty @%0t: got valid with no pending start, want none", $time);
      end else begin
        e       = sb.pop_front();
        h_code  = e.code;
        h_level = e.level;
        h_err   = e.err;
      end
    end
    n_vec++;
    if (oCode !== h_code || oLevel !== h_level) begin
      n_bad++;
      $display("FAIL result @%0t: got code %h level %h want code %h level %h",
               $time, oCode, oLevel, h_code, h_level);
    end
`ifdef SID_ADC_ERR_EN
    n_vec++;
    if (oErr !== h_err) begin
      n_bad++;
      $display("FAIL err @%0t: got %h want %h", $time, oErr, h_err);
    end
`endif
  end

  task automatic run_one(input logic [7:0] t, output logic [7:0] code,
                         output logic [7:0] level, output int lat);
    @(negedge clk);
    iTarget = t;
    iStart  = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    lat = 1;
    while (oValid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    code  = oCode;
    level = oLevel;
  endtask

  task automatic test_reset();
    iRstN   = 1'b0;
    iStart  = 1'b1;
    iTarget = 8'h55;
    repeat (3) @(negedge clk);
    n_vec++;
    if (oBusy !== 1'b0 || oValid !== 1'b0 || oCode !== 8'h00 || oLevel !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_hold: got busy %b valid %b code %h level %h want 0 0 00 00",
               oBusy, oValid, oCode, oLevel);
    end
    iStart = 1'b0;
    #2 iRstN = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if (oBusy !== 1'b0 || oValid !== 1'b0 || oCode !== 8'h00 || oLevel !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_release: got busy %b valid %b code %h level %h want 0 0 00 00",
               oBusy, oValid, oCode, oLevel);
    end
  endtask

  task automatic test_known();
    logic [7:0] c, l;
    int lat;
    logic [7:0] tv [3] = '{8'hFF, 8'h00, 8'h80};
    logic [7:0] cv [3] = '{8'hFF, 8'h00, 8'h84};
    logic [7:0] lv [3] = '{8'hFF, 8'h00, 8'h80};
    for (int i = 0; i < 3; i++) begin
      run_one(tv[i], c, l, lat);
      n_vec++;
      if (lat != 9) begin
        n_bad++;
        $display("FAIL latency t=%h: got %0d cycles want 9", tv[i], lat);
      end
      n_vec++;
      if (c !== cv[i] || l !== lv[i]) begin
        n_bad++;
        $display("FAIL known t=%h: got code %h level %h want code %h level %h",
                 tv[i], c, l, cv[i], lv[i]);
      end
`ifdef SID_ADC_ERR_EN
      n_vec++;
      if (oErr !== tv[i] - lv[i]) begin
        n_bad++;
        $display("FAIL known_err t=%h: got %h want %h", tv[i], oErr, tv[i] - lv[i]);
      end
`endif
    end
  endtask

  task automatic test_sweep();
    logic [7:0] c, l;
    int lat;
    for (int t = 0; t < 256; t++) begin
      run_one(t[7:0], c, l, lat);
      n_vec++;
      if (lat != 9 || l > t[7:0]) begin
        n_bad++;
        $display("FAIL sweep t=%h: got lat %0d level %h want lat 9 level <= target",
                 t[7:0], lat, l);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int last = -1;
    int cyc = 0;
    @(negedge clk);
    iTarget = 8'($urandom_range(0, 255));
    iStart  = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      cyc++;
      if (oValid === 1'b1) begin
        if (last >= 0) begin
          n_vec++;
          if (cyc - last != 9) begin
            n_bad++;
            $display("FAIL b2b_period: got %0d cycles want 9", cyc - last);
          end
        end
        last = cyc;
        pulses++;
      end
      iTarget = 8'($urandom_range(0, 255));
    end
    iStart = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cyc++;
      if (oValid === 1'b1) begin
        pulses++;
        last = cyc;
      end
    end
    n_vec++;
    if (pulses != 4) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d completions want 4", pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] c, l;
    int lat;
    @(negedge clk);
    iTarget = 8'hC3;
    iStart  = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    repeat (3) @(negedge clk);
    #2 iRstN = 1'b0;
    @(negedge clk);
    n_vec++;
    if (oBusy !== 1'b0 || oValid !== 1'b0 || oCode !== 8'h00 || oLevel !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid: got busy %b valid %b code %h level %h want 0 0 00 00",
               oBusy, oValid, oCode, oLevel);
    end
    @(negedge clk);
    #2 iRstN = 1'b1;
    repeat (12) @(negedge clk);
    run_one(8'h80, c, l, lat);
    n_vec++;
    if (lat != 9 || c !== 8'h84 || l !== 8'h80) begin
      n_bad++;
      $display("FAIL after_reset: got lat %0d code %h level %h want lat 9 code 84 level 80",
               lat, c, l);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_known();
    test_sweep();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d pending results want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
